// File: rtl/coin_acceptor_if.sv
// -----------------------------------------------------------------------------
// coin_acceptor_if
//   Deposit handshake between the coin acceptor (producer) and the dispenser
//   (consumer). A deposit transfers in any cycle where deposit_valid_o and
//   deposit_ready_i are both high.
//
//   Signals:
//     deposit_o        6  offered deposit in cents
//     deposit_valid_o  1  deposit_o is valid
//     deposit_ready_i  1  dispenser accepts the deposit
//
//   Modports:
//     master  producer side (coin_acceptor)
//     slave   consumer side (dispenser)
// -----------------------------------------------------------------------------
interface coin_acceptor_if;
   logic [5:0] deposit_o;
   logic       deposit_valid_o;
   logic       deposit_ready_i;

   modport master (
      output deposit_o,
      output deposit_valid_o,
      input  deposit_ready_i
   );

   modport slave (
      input  deposit_o,
      input  deposit_valid_o,
      output deposit_ready_i
   );
endinterface

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//   Credit accumulator for the vending datapath. Accepts single-cycle coin
//   pulses (5/10/25 cents), accumulates credit, and once credit reaches PRICE
//   offers the total to the dispenser over the deposit handshake. A customer
//   cancel refunds the accumulated credit. All outputs are registered.
//
//   Parameters:
//     PRICE           item price in cents (multiple of 5, PRICE+20 <= 63)
//     TIMEOUT_CYCLES  idle COLLECT cycles before auto-refund
//
//   Optional build macro:
//     COIN_TIMEOUT_EN  when defined, COLLECT auto-refunds after TIMEOUT_CYCLES
//                      cycles without a valid coin; otherwise COLLECT waits
//                      indefinitely and no counter is built.
//
//   Ports:
//     clk_i           clock, rising edge
//     rst_ni          asynchronous reset, active low
//     nickel_i        one-cycle pulse, 5-cent coin
//     dime_i          one-cycle pulse, 10-cent coin
//     quarter_i       one-cycle pulse, 25-cent coin
//     cancel_i        one-cycle pulse, customer cancel
//     dep_if          deposit handshake (master): deposit_o, deposit_valid_o,
//                     deposit_ready_i
//     refund_o        refunded amount in cents
//     refund_valid_o  one-cycle refund strobe
//     coin_reject_o   one-cycle pulse; coin returned, not credited
//     credit_o        current accumulated credit, for display
// -----------------------------------------------------------------------------
module coin_acceptor #(
   parameter int unsigned PRICE          = 20,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   nickel_i,
   input  logic                   dime_i,
   input  logic                   quarter_i,
   input  logic                   cancel_i,
   coin_acceptor_if.master        dep_if,
   output logic [5:0]             refund_o,
   output logic                   refund_valid_o,
   output logic                   coin_reject_o,
   output logic [5:0]             credit_o
);

   // Elaboration-time guard on the parameter constraints that keep the 6-bit
   // credit adder from wrapping.
   if ((PRICE % 5) != 0 || PRICE == 0 || (PRICE + 20) > 63 || TIMEOUT_CYCLES < 1)
   begin : g_param_check
      $error("coin_acceptor: illegal PRICE or TIMEOUT_CYCLES");
   end

   localparam logic [5:0] PRICE_C = 6'(PRICE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_OFFER   = 2'd2,
      S_REFUND  = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [5:0] credit_q, credit_d;
   logic [5:0] deposit_q, deposit_d;
   logic       dep_valid_q, dep_valid_d;
   logic [5:0] refund_q, refund_d;
   logic       refund_valid_q, refund_valid_d;
   logic       reject_q, reject_d;

   logic       coin_any;
   logic       coin_one;
   logic [5:0] coin_val;
   logic [5:0] credit_sum;

`ifdef COIN_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Coin decode: only a single asserted coin line is a valid coin.
   always_comb begin
      coin_any = nickel_i | dime_i | quarter_i;
      coin_one = $onehot({nickel_i, dime_i, quarter_i});
      coin_val = '0;
      if (coin_one) begin
         if (nickel_i)      coin_val = 6'd5;
         else if (dime_i)   coin_val = 6'd10;
         else               coin_val = 6'd25;
      end
      credit_sum = credit_q + coin_val;
   end

   // Next-state and registered-output values. Output registers are loaded
   // with the values the next state presents, so a coin sampled in cycle N
   // is visible on credit_o / deposit_valid_o in cycle N+1.
   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      deposit_d      = '0;
      dep_valid_d    = 1'b0;
      refund_d       = '0;
      refund_valid_d = 1'b0;
      reject_d       = 1'b0;
`ifdef COIN_TIMEOUT_EN
      tmo_d          = '0;
`endif

      unique case (state_q)
         S_IDLE: begin
            // cancel_i is ignored here: there is nothing to refund.
            credit_d = '0;
            if (coin_one) begin
               credit_d = coin_val;
               if (coin_val >= PRICE_C) begin
                  state_d     = S_OFFER;
                  dep_valid_d = 1'b1;
                  deposit_d   = coin_val;
               end else begin
                  state_d = S_COLLECT;
               end
            end else if (coin_any) begin
               reject_d = 1'b1;
            end
         end

         S_COLLECT: begin
            if (cancel_i) begin
               // Cancel wins over any coin in the same cycle; that coin is
               // returned and only the prior credit is refunded.
               state_d        = S_REFUND;
               refund_d       = credit_q;
               refund_valid_d = 1'b1;
               reject_d       = coin_any;
            end else if (coin_one) begin
               credit_d = credit_sum;
               if (credit_sum >= PRICE_C) begin
                  state_d     = S_OFFER;
                  dep_valid_d = 1'b1;
                  deposit_d   = credit_sum;
               end
            end else begin
               reject_d = coin_any;
`ifdef COIN_TIMEOUT_EN
               // The transition fires on the cycle that would bring the count
               // to TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES idle cycles
               // elapse before the refund strobe.
               if (tmo_q == TMO_LAST) begin
                  state_d        = S_REFUND;
                  refund_d       = credit_q;
                  refund_valid_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
`endif
            end
         end

         S_OFFER: begin
            // Sale is committed: cancel ignored, coins returned.
            reject_d = coin_any;
            if (dep_valid_q && dep_if.deposit_ready_i) begin
               state_d  = S_IDLE;
               credit_d = '0;
            end else begin
               dep_valid_d = 1'b1;
               deposit_d   = credit_q;
            end
         end

         S_REFUND: begin
            reject_d = coin_any;
            state_d  = S_IDLE;
            credit_d = '0;
         end

         default: begin
            state_d  = S_IDLE;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         deposit_q      <= '0;
         dep_valid_q    <= 1'b0;
         refund_q       <= '0;
         refund_valid_q <= 1'b0;
         reject_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         deposit_q      <= deposit_d;
         dep_valid_q    <= dep_valid_d;
         refund_q       <= refund_d;
         refund_valid_q <= refund_valid_d;
         reject_q       <= reject_d;
      end
   end

`ifdef COIN_TIMEOUT_EN
   // Held at 0 outside COLLECT because tmo_d defaults to 0 in other states.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign dep_if.deposit_o       = deposit_q;
   assign dep_if.deposit_valid_o = dep_valid_q;
   assign refund_o               = refund_q;
   assign refund_valid_o         = refund_valid_q;
   assign coin_reject_o          = reject_q;
   assign credit_o               = credit_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//   Directed self-checking bench for coin_acceptor (PRICE = 20). Timeout
//   scenarios are compiled in only when COIN_TIMEOUT_EN is defined; the DUT is
//   always built with TIMEOUT_CYCLES = 8.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       nickel_i = 1'b0;
   logic       dime_i = 1'b0;
   logic       quarter_i = 1'b0;
   logic       cancel_i = 1'b0;
   logic [5:0] refund_o;
   logic       refund_valid_o;
   logic       coin_reject_o;
   logic [5:0] credit_o;

   int n_checks = 0;
   int n_fail   = 0;

   coin_acceptor_if dep_if ();

   coin_acceptor #(
      .PRICE          (20),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .nickel_i       (nickel_i),
      .dime_i         (dime_i),
      .quarter_i      (quarter_i),
      .cancel_i       (cancel_i),
      .dep_if         (dep_if.master),
      .refund_o       (refund_o),
      .refund_valid_o (refund_valid_o),
      .coin_reject_o  (coin_reject_o),
      .credit_o       (credit_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Apply a one-cycle input pattern {nickel, dime, quarter, cancel}.
   task automatic pulse(input logic n, input logic d, input logic q, input logic c);
      nickel_i  = n;
      dime_i    = d;
      quarter_i = q;
      cancel_i  = c;
      tick();
      nickel_i  = 1'b0;
      dime_i    = 1'b0;
      quarter_i = 1'b0;
      cancel_i  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".deposit"},      32'(dep_if.deposit_o),       0);
      check({tag, ".dep_valid"},    32'(dep_if.deposit_valid_o), 0);
      check({tag, ".refund"},       32'(refund_o),               0);
      check({tag, ".refund_valid"}, 32'(refund_valid_o),         0);
      check({tag, ".reject"},       32'(coin_reject_o),          0);
      check({tag, ".credit"},       32'(credit_o),               0);
   endtask

   initial begin
      dep_if.deposit_ready_i = 1'b0;

      // Reset
      #1 rst_ni = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      check_all_zero("post_reset");

      // Exact price: dime, dime with ready high
      dep_if.deposit_ready_i = 1'b1;
      pulse(0, 1, 0, 0);
      check("exact.credit1",    32'(credit_o),               10);
      check("exact.valid1",     32'(dep_if.deposit_valid_o), 0);
      pulse(0, 1, 0, 0);
      check("exact.credit2",    32'(credit_o),               20);
      check("exact.valid2",     32'(dep_if.deposit_valid_o), 1);
      check("exact.deposit",    32'(dep_if.deposit_o),       20);
      tick();
      check("exact.valid_done", 32'(dep_if.deposit_valid_o), 0);
      check("exact.credit_done", 32'(credit_o),              0);

      // Overpay with backpressure: 5 + 10 + 25 = 40, nickel during the wait
      dep_if.deposit_ready_i = 1'b0;
      pulse(1, 0, 0, 0);
      check("over.credit1", 32'(credit_o), 5);
      pulse(0, 1, 0, 0);
      check("over.credit2", 32'(credit_o), 15);
      pulse(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("over.valid%0d", i),   32'(dep_if.deposit_valid_o), 1);
         check($sformatf("over.deposit%0d", i), 32'(dep_if.deposit_o),       40);
         check($sformatf("over.reject%0d", i),  32'(coin_reject_o),          (i == 3) ? 1 : 0);
         check($sformatf("over.credit%0d", i),  32'(credit_o),               40);
         pulse((i == 2), 0, 0, 0);
      end
      dep_if.deposit_ready_i = 1'b1;
      check("over.valid_at_ready", 32'(dep_if.deposit_valid_o), 1);
      check("over.dep_at_ready",   32'(dep_if.deposit_o),       40);
      tick();
      check("over.valid_done",  32'(dep_if.deposit_valid_o), 0);
      check("over.credit_done", 32'(credit_o),               0);

      // Cancel: 5 + 10 then cancel refunds 15
      pulse(1, 0, 0, 0);
      check("cancel.valid_a", 32'(dep_if.deposit_valid_o), 0);
      pulse(0, 1, 0, 0);
      check("cancel.valid_b", 32'(dep_if.deposit_valid_o), 0);
      pulse(0, 0, 0, 1);
      check("cancel.refund_valid", 32'(refund_valid_o),         1);
      check("cancel.refund",       32'(refund_o),               15);
      check("cancel.valid_c",      32'(dep_if.deposit_valid_o), 0);
      tick();
      check("cancel.refund_valid_off", 32'(refund_valid_o),         0);
      check("cancel.credit_done",      32'(credit_o),               0);
      check("cancel.valid_d",          32'(dep_if.deposit_valid_o), 0);
      // Cancel in IDLE: no strobe
      pulse(0, 0, 0, 1);
      check("idle_cancel.refund_valid", 32'(refund_valid_o), 0);
      tick();
      check("idle_cancel.refund_valid2", 32'(refund_valid_o), 0);

      // Simultaneous coins from IDLE
      pulse(1, 1, 0, 0);
      check("multi.reject", 32'(coin_reject_o), 1);
      check("multi.credit", 32'(credit_o),      0);
      tick();
      check("multi.reject_off", 32'(coin_reject_o), 0);
      // Dime plus cancel with credit 5
      pulse(1, 0, 0, 0);
      check("dc.credit", 32'(credit_o), 5);
      pulse(0, 1, 0, 1);
      check("dc.refund_valid", 32'(refund_valid_o), 1);
      check("dc.refund",       32'(refund_o),       5);
      check("dc.reject",       32'(coin_reject_o),  1);
      tick();
      check("dc.credit_done", 32'(credit_o), 0);

      // Reset mid-offer: quarter -> 25 in OFFER, ready low
      dep_if.deposit_ready_i = 1'b0;
      pulse(0, 0, 1, 0);
      check("rst.valid",   32'(dep_if.deposit_valid_o), 1);
      check("rst.deposit", 32'(dep_if.deposit_o),       25);
      #2 rst_ni = 1'b0;
      #1;
      check_all_zero("rst.async");
      @(negedge clk_i);
      rst_ni = 1'b1;
      dep_if.deposit_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rst.after_valid%0d", i),  32'(dep_if.deposit_valid_o), 0);
         check($sformatf("rst.after_refund%0d", i), 32'(refund_valid_o),         0);
      end

`ifdef COIN_TIMEOUT_EN
      // Dime then 8 idle cycles -> refund of 10
      pulse(0, 1, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         tick();
         check($sformatf("tmo.no_refund%0d", i), 32'(refund_valid_o), 0);
      end
      tick();
      check("tmo.refund_valid", 32'(refund_valid_o), 1);
      check("tmo.refund",       32'(refund_o),       10);
      tick();
      check("tmo.refund_off", 32'(refund_valid_o), 0);
      // Nickel at idle cycle 6 restarts the count
      pulse(0, 1, 0, 0);
      for (int i = 1; i <= 5; i++) tick();
      pulse(1, 0, 0, 0);
      check("tmo2.credit", 32'(credit_o), 15);
      for (int i = 1; i <= 7; i++) begin
         tick();
         check($sformatf("tmo2.no_refund%0d", i), 32'(refund_valid_o), 0);
      end
      tick();
      check("tmo2.refund_valid", 32'(refund_valid_o), 1);
      check("tmo2.refund",       32'(refund_o),       15);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
